// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared FSM encoding and FIFO sizing for the pixel streamer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TAG_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pix_fifo.sv
// ============================================================================
// Module      : pix_fifo
// Description : Small pixel+tag FIFO with registered occupancy count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pix_fifo
    import cnn_pkg::*;
#(
    parameter int DW = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DW-1:0]         i_data,
    input  logic                  i_pop,
    output logic [DW-1:0]         o_data,
    output logic                  o_empty,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [DW-1:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_push;
    logic                  w_pop;

    // A pop frees the slot this cycle, so a push into a full FIFO is legal then.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + FIFO_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pixel_streamer.sv
// ============================================================================
// Module      : pixel_streamer
// Description : Reads a frame from memory in raster order and streams it out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pixel_streamer
    import cnn_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COL_NUM = 128,
    parameter int ROW_NUM = 128,
    parameter int ADDR_W  = 14,
    parameter int ROW_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [WIDTH-1:0]  dout,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done
);

    localparam int          c_DW       = WIDTH + TAG_W;
    localparam int          c_LVL_W    = FIFO_CNT_W + 1;
    localparam logic [10:0] c_COL_LAST = 11'(COL_NUM - 1);
    localparam logic [10:0] c_ROW_LAST = 11'(ROW_NUM - 1);
    localparam logic [10:0] c_GAP_LAST = 11'(ROW_GAP - 1);

    state_t              r_state;
    logic [10:0]         r_col;
    logic [10:0]         r_row;
    logic [10:0]         r_gap;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_inflight;
    logic [TAG_W-1:0]    r_tag_fl;
    logic                r_busy;
    logic                r_done;

    logic                w_pop;
    logic                w_rd;
    logic                w_empty;
    logic                w_col_last;
    logic                w_row_last;
    logic [FIFO_CNT_W-1:0] w_count;
    logic [c_LVL_W-1:0]  w_level;
    logic [c_DW-1:0]     w_head;

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);
    assign w_pop      = !w_empty && ready_in;

    // Slots committed after this edge; counting the pop lets a full FIFO keep reading.
    assign w_level = {1'b0, w_count} + c_LVL_W'(r_inflight) - c_LVL_W'(w_pop);
    assign w_rd    = (r_state == ST_READ) && (w_level < c_LVL_W'(FIFO_DEPTH));

    // Memory answers exactly one cycle after the strobe; reset drops any pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_tag_fl   <= '0;
        end else begin
            r_inflight <= w_rd;
            r_tag_fl   <= {(r_row == '0) && (r_col == '0), w_col_last, w_col_last && w_row_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_gap   <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_rd) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_col_last) begin
                            r_col <= '0;
                            r_gap <= '0;
                            if (w_row_last) begin
                                r_row   <= '0;
                                r_state <= ST_DRAIN;
                            end else begin
                                r_row <= r_row + 11'(1);
                                if (ROW_GAP != 0) begin
                                    r_state <= ST_GAP;
                                end
                            end
                        end else begin
                            r_col <= r_col + 11'(1);
                        end
                    end
                end
                ST_GAP: begin
                    r_gap <= r_gap + 11'(1);
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= ST_READ;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && !r_inflight) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    pix_fifo #(
        .DW (c_DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  ({r_tag_fl, rd_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign rd_en     = w_rd;
    assign rd_addr   = r_addr;
    assign valid_out = !w_empty;
    assign {sof, eol, eof, dout} = w_head;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pixel_streamer.sv
// ============================================================================
// Module      : tb_pixel_streamer
// Description : Scoreboard bench for pixel_streamer (4x3 frame, gap 2 and gap 0).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pixel_streamer;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int R  = 3;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          ready_in;

    logic          rd_en, valid_out, sof, eol, eof, busy, done;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data, dout;

    logic          rd_en0, valid_out0, sof0, eol0, eof0, busy0, done0;
    logic [AW-1:0] rd_addr0;
    logic [W-1:0]  rd_data0, dout0;

    pixel_streamer #(.WIDTH(W), .COL_NUM(C), .ROW_NUM(R), .ADDR_W(AW), .ROW_GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .ready_in(ready_in),
        .valid_out(valid_out), .dout(dout), .sof(sof), .eol(eol), .eof(eof),
        .busy(busy), .done(done)
    );

    pixel_streamer #(.WIDTH(W), .COL_NUM(C), .ROW_NUM(R), .ADDR_W(AW), .ROW_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .ready_in(ready_in),
        .valid_out(valid_out0), .dout(dout0), .sof(sof0), .eol(eol0), .eof(eof0),
        .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    // Frame memory: word = low byte of the address, one cycle read latency.
    always @(posedge clk) if (rd_en)  rd_data  <= rd_addr[7:0];
    always @(posedge clk) if (rd_en0) rd_data0 <= rd_addr0[7:0];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W+2:0] q[$];

    task automatic push_frame(input logic [AW-1:0] b);
        logic [AW-1:0] a;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                a = b + AW'(r * C + c);
                q.push_back({(r == 0 && c == 0), (c == C - 1), (c == C - 1 && r == R - 1), a[7:0]});
            end
        end
    endtask

    // Monitor for the ROW_GAP=2 instance.
    bit           mon_en = 0;
    bit           gap_chk = 0;
    bit           stalled = 0;
    bit           after_eol = 0;
    int           idle_run = 0;
    int           n_out = 0;
    int           n_done = 0;
    logic [W+2:0] held;

    always @(negedge clk) begin
        if (!mon_en) begin
            stalled = 0;
        end else begin
            if (stalled && valid_out) check("stall_hold", {sof, eol, eof, dout}, held);
            stalled = valid_out && !ready_in;
            held    = {sof, eol, eof, dout};
            if (valid_out && ready_in) begin
                if (gap_chk && after_eol) check("row_gap", idle_run, 2);
                after_eol = eol && !eof;
                idle_run  = 0;
                if (q.size() == 0) check("extra_pixel", {sof, eol, eof, dout}, 0);
                else               check("pixel", {sof, eol, eof, dout}, q.pop_front());
                n_out++;
            end else if (!valid_out) begin
                idle_run++;
            end
            if (done) n_done++;
        end
    end

    // Monitor for the ROW_GAP=0 instance: longest run of valid cycles.
    bit mon0_en = 0;
    int run0 = 0, max0 = 0, v0 = 0;

    always @(negedge clk) begin
        if (mon0_en) begin
            if (valid_out0) begin
                run0++;
                v0++;
                if (run0 > max0) max0 = run0;
            end else begin
                run0 = 0;
            end
        end
    end

    bit            alog_en = 0;
    int            n_addr = 0;
    logic [AW-1:0] alog [3];

    always @(negedge clk) begin
        if (alog_en && rd_en && n_addr < 3) begin
            alog[n_addr] = rd_addr;
            n_addr++;
        end
    end

    task automatic pulse_start(input logic [AW-1:0] b);
        @(posedge clk); #1;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input int n0);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (n_done > n0) ok = 1;
        end
        check({tag, "_done_seen"}, ok, 1);
    endtask

    function automatic logic [31:0] outs();
        return {3'b0, rd_en, rd_addr, valid_out, dout, sof, eol, eof, busy, done};
    endfunction

    initial begin
        int o0, d0, nrd;
        bit ok;
        rst = 1'b1; start = 1'b0; base_addr = '0; ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        rst = 1'b0;

        // Basic frame, latency, row gaps; gap-0 instance streams in parallel.
        o0 = n_out; d0 = n_done;
        push_frame(14'h010);
        gap_chk = 1; mon_en = 1; mon0_en = 1;
        pulse_start(14'h010);
        check("rd_en_latency", rd_en, 1);
        @(posedge clk); #1; check("valid_T2", valid_out, 0);
        @(posedge clk); #1; check("valid_T3", valid_out, 1);
        check("busy_running", busy, 1);
        wait_done("frame1", 100, d0);
        check("frame1_count", n_out - o0, 12);
        check("frame1_sb_empty", q.size(), 0);
        check("frame1_one_done", n_done - d0, 1);
        @(posedge clk); #1;
        check("busy_idle", busy, 0);
        check("done_cleared", done, 0);
        check("gap0_run", max0, 12);
        check("gap0_total", v0, 12);
        gap_chk = 0; mon0_en = 0;

        // ready_in toggling, plus an ignored start mid-frame.
        o0 = n_out; d0 = n_done;
        push_frame(14'h010);
        pulse_start(14'h010);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            ready_in = ~ready_in;
            if (i == 6) begin
                start = 1'b1; base_addr = 14'h030;
            end else begin
                start = 1'b0;
            end
            if (n_done > d0) ok = 1;
        end
        ready_in = 1'b1;
        check("toggle_done_seen", ok, 1);
        check("toggle_count", n_out - o0, 12);
        check("toggle_sb_empty", q.size(), 0);

        // Long stall: reads must stop at four outstanding.
        @(posedge clk); #1;
        o0 = n_out; d0 = n_done;
        push_frame(14'h010);
        ready_in = 1'b0;
        pulse_start(14'h010);
        nrd = rd_en ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            if (rd_en) nrd++;
        end
        check("stall_reads", nrd, 4);
        check("stall_valid", valid_out, 1);
        check("stall_head", dout, 8'h10);
        ready_in = 1'b1;
        wait_done("stall", 100, d0);
        check("stall_count", n_out - o0, 12);

        // Reset with the 6th pixel pending, then a clean frame.
        @(posedge clk); #1;
        o0 = n_out; d0 = n_done;
        push_frame(14'h010);
        pulse_start(14'h010);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (n_out - o0 >= 5) ok = 1;
        end
        check("midrst_reached", ok, 1);
        mon_en = 0;
        rst = 1'b1;
        #1;
        check("midrst_outputs", outs(), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        mon_en = 1;
        o0 = n_out; d0 = n_done;
        push_frame(14'h010);
        pulse_start(14'h010);
        wait_done("after_rst", 100, d0);
        check("after_rst_count", n_out - o0, 12);
        check("after_rst_sb_empty", q.size(), 0);

        // Address wrap at the top of memory.
        @(posedge clk); #1;
        o0 = n_out; d0 = n_done;
        push_frame(14'h3FFE);
        alog_en = 1;
        pulse_start(14'h3FFE);
        wait_done("wrap", 100, d0);
        check("wrap_count", n_out - o0, 12);
        check("wrap_addr0", alog[0], 14'h3FFE);
        check("wrap_addr1", alog[1], 14'h3FFF);
        check("wrap_addr2", alog[2], 14'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 Parameter WIDTH, default 8, sets pixel data width.
REQ-002 Parameter COL_NUM, default 128, sets pixels per row.
REQ-003 Parameter ROW_NUM, default 128, sets rows per frame.
REQ-004 Parameter ADDR_W, default 14, sets frame-memory address width.
REQ-005 Parameter ROW_GAP, default 2, sets idle cycles inserted between rows (0 allowed).
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: single-cycle request to stream one frame.
REQ-009 Port base_addr, input, ADDR_W bits: frame start address, sampled with start.
REQ-010 Port rd_en, output, 1 bit: frame-memory read strobe.
REQ-011 Port rd_addr, output, ADDR_W bits: frame-memory read address.
REQ-012 Port rd_data, input, WIDTH bits: read data, valid exactly 1 cycle after rd_en.
REQ-013 Port ready_in, input, 1 bit: downstream may accept a pixel (tie high for linebuffer use).
REQ-014 Port valid_out, output, 1 bit: dout holds a valid pixel (drives linebuffer valid_in).
REQ-015 Port dout, output, WIDTH bits: raster pixel, left-to-right, then top-to-bottom.
REQ-016 Ports sof, eol and eof, outputs, 1 bit each: tags qualified by valid_out.
REQ-017 Port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-018 Port done, output, 1 bit: one-cycle pulse after the last pixel is transferred.

Function
REQ-019 The FSM SHALL have states IDLE, READ, GAP, DRAIN and DONE.
REQ-020 IDLE transitions to READ on start; start SHALL be ignored in any other state.
REQ-021 READ SHALL issue rd_en with rd_addr = base_addr + row*COL_NUM + col, incremented per read and wrapping modulo 2^ADDR_W.
REQ-022 rd_en SHALL assert only in READ and only when FIFO occupancy plus in-flight reads is less than 4.
REQ-023 After the read of col COL_NUM-1, the FSM SHALL go to GAP for ROW_GAP cycles, or straight back to READ if ROW_GAP=0.
REQ-024 After the read of the last pixel of the last row, the FSM SHALL go to DRAIN, skipping GAP.
REQ-025 DRAIN SHALL go to DONE when the FIFO is empty and nothing is in flight.
REQ-026 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-027 Returned rd_data SHALL be pushed, with tag bits {sof,eol,eof}, into a 4-entry FIFO; the FIFO SHALL never overflow.
REQ-028 valid_out SHALL equal FIFO non-empty; a transfer occurs when valid_out and ready_in are both high.
REQ-029 dout and tags SHALL hold stable while valid_out=1 and ready_in=0.
REQ-030 sof SHALL mark pixel (0,0), eol SHALL mark col COL_NUM-1, and eof SHALL mark pixel (ROW_NUM-1, COL_NUM-1); eof implies eol.
REQ-031 With ready_in held high, start sampled at edge T SHALL give rd_en at T+1, the first valid_out at T+3, and one pixel per cycle within a row.
REQ-032 A push and a pop in the same cycle SHALL leave occupancy unchanged; a pop on a full FIFO SHALL allow a read that cycle.
REQ-033 Row and column counters SHALL be 11 bits wide and wrap to 0 at COL_NUM-1 and ROW_NUM-1.

Reset
REQ-034 On rst, the FSM SHALL go to IDLE, and the FIFO and in-flight count SHALL clear.
REQ-035 On rst, rd_en, rd_addr, valid_out, dout, sof, eol, eof, busy and done SHALL all be 0.
REQ-036 rd_data returning after a mid-frame reset SHALL be discarded.

Structure
REQ-037 The FSM state encoding and FIFO depth constant (4) SHALL live in shared package cnn_pkg.
REQ-038 The FIFO SHALL be a separate sub-module, pix_fifo (WIDTH+3 bits wide, 4 deep, registered occupancy).

Verification (COL_NUM=4, ROW_NUM=3, ROW_GAP=2, base_addr=0x010, memory word = address low byte)
REQ-039 start with ready_in=1 -> 12 pixels 0x10..0x1B; sof on 0x10; eol on 0x13, 0x17 and 0x1B; eof on 0x1B; exactly 2 idle cycles between rows; one done pulse.
REQ-040 ready_in toggled 1,0,1,0 per cycle -> the same 12 pixels in order, no loss or duplication, and dout stable while stalled.
REQ-041 ready_in=0 for 20 cycles after start -> rd_en stops after 4 reads in flight/queued, then streaming resumes with the correct order.
REQ-042 rst asserted while the 6th pixel is pending -> all outputs 0 next cycle; a new start yields a full clean frame beginning at 0x10.
REQ-043 start re-pulsed mid-frame -> ignored; base_addr=0x3FFE gives addresses wrapping 0x3FFE, 0x3FFF, 0x0000.
REQ-044 ROW_GAP=0 build -> 12 consecutive valid cycles with no bubbles.
